// File: rtl/ex_wb_writeback.sv
// FPU EX/WB retirement stage: in-order result queue draining to the register-file
// write port, with the producer side of operand forwarding and the hazard stall.
module ex_wb_writeback #(
  parameter int DSIZE = 32,
  parameter int ASIZE = 5,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ex_valid,
  output logic                     ex_ready,
  input  logic                     ex_wen,
  input  logic [ASIZE-1:0]         ex_rd_addr,
  input  logic [DSIZE-1:0]         ex_result,
  output logic                     rf_we,
  output logic [ASIZE-1:0]         rf_waddr,
  output logic [DSIZE-1:0]         rf_wdata,
  input  logic                     rf_grant,
  output logic [ASIZE-1:0]         EX_WB_RDAddr,
  output logic [DSIZE-1:0]         FromEX,
  output logic                     fwd_valid,
  input  logic [ASIZE-1:0]         RLAddr,
  input  logic [ASIZE-1:0]         RRAddr,
  output logic                     hazard_stall,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic             r_wen  [DEPTH];
  logic [ASIZE-1:0] r_addr [DEPTH];
  logic [DSIZE-1:0] r_data [DEPTH];
  logic [PW-1:0]    r_head;
  logic [PW-1:0]    r_tail;
  logic [CW-1:0]    r_count;

  logic             w_push;
  logic             w_pop;
  logic [PW-1:0]    w_idx [DEPTH];
  logic [DEPTH-1:0] w_live;
  logic             w_fv;
  logic [ASIZE-1:0] w_fa;
  logic [DSIZE-1:0] w_fd;
  logic             w_hit_l;
  logic             w_hit_r;

  assign ex_ready = !rst && (r_count < CW'(DEPTH));
  assign w_push   = ex_valid && ex_ready;
  // A wen=0 head retires without waiting for the register file.
  assign w_pop    = (r_count != CW'(0)) && (!r_wen[r_head] || rf_grant);

  // Slot g is the g-th oldest entry; live means it is occupied and writes the RF.
  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    assign w_idx[g]  = r_head + PW'(g);
    assign w_live[g] = (CW'(g) < r_count) && r_wen[w_idx[g]];
  end

  // Queue storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= PW'(0);
      r_tail  <= PW'(0);
      r_count <= CW'(0);
      for (int i = 0; i < DEPTH; i++) begin
        r_wen[i]  <= 1'b0;
        r_addr[i] <= ASIZE'(0);
        r_data[i] <= DSIZE'(0);
      end
    end else begin
      if (w_push) begin
        r_wen[r_tail]  <= ex_wen;
        r_addr[r_tail] <= ex_rd_addr;
        r_data[r_tail] <= ex_result;
        r_tail         <= r_tail + PW'(1);
      end
      if (w_pop) begin
        r_head <= r_head + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Oldest-to-youngest scan so the youngest writer ends up on the forward bus.
  always_comb begin
    w_fv    = 1'b0;
    w_fa    = ASIZE'(0);
    w_fd    = DSIZE'(0);
    w_hit_l = 1'b0;
    w_hit_r = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      w_fv    = w_fv | w_live[i];
      w_fa    = w_live[i] ? r_addr[w_idx[i]] : w_fa;
      w_fd    = w_live[i] ? r_data[w_idx[i]] : w_fd;
      w_hit_l = w_hit_l | (w_live[i] && (r_addr[w_idx[i]] == RLAddr));
      w_hit_r = w_hit_r | (w_live[i] && (r_addr[w_idx[i]] == RRAddr));
    end
  end

  // rf_we is masked during reset so no write completes on the clearing edge.
  assign rf_we        = !rst && (r_count != CW'(0)) && r_wen[r_head];
  assign rf_waddr     = rf_we ? r_addr[r_head] : ASIZE'(0);
  assign rf_wdata     = rf_we ? r_data[r_head] : DSIZE'(0);
  assign fwd_valid    = w_fv;
  assign EX_WB_RDAddr = w_fa;
  assign FromEX       = w_fd;
  // An older writer to the youngest forwarded address is shadowed, so it never stalls.
  assign hazard_stall = (w_hit_l && (RLAddr != w_fa)) || (w_hit_r && (RRAddr != w_fa));
  assign occupancy    = r_count;

endmodule

// File: tb/tb_ex_wb_writeback.sv
// Bench for ex_wb_writeback: directed vector table, then random and wrap traffic
// checked against a queue-based reference model.
module tb_ex_wb_writeback;

  localparam int DSIZE = 32;
  localparam int ASIZE = 5;
  localparam int DEPTH = 2;

  logic             clk;
  logic             rst;
  logic             ex_valid;
  logic             ex_ready;
  logic             ex_wen;
  logic [ASIZE-1:0] ex_rd_addr;
  logic [DSIZE-1:0] ex_result;
  logic             rf_we;
  logic [ASIZE-1:0] rf_waddr;
  logic [DSIZE-1:0] rf_wdata;
  logic             rf_grant;
  logic [ASIZE-1:0] EX_WB_RDAddr;
  logic [DSIZE-1:0] FromEX;
  logic             fwd_valid;
  logic [ASIZE-1:0] RLAddr;
  logic [ASIZE-1:0] RRAddr;
  logic             hazard_stall;
  logic [$clog2(DEPTH):0] occupancy;

  ex_wb_writeback #(.DSIZE(DSIZE), .ASIZE(ASIZE), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_wen(ex_wen), .ex_rd_addr(ex_rd_addr), .ex_result(ex_result),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_grant(rf_grant),
    .EX_WB_RDAddr(EX_WB_RDAddr), .FromEX(FromEX), .fwd_valid(fwd_valid),
    .RLAddr(RLAddr), .RRAddr(RRAddr), .hazard_stall(hazard_stall),
    .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             wen;
    logic [ASIZE-1:0] addr;
    logic [DSIZE-1:0] data;
  } ent_t;

  typedef struct {
    int rst, vld, wen, rd, res, gnt, rl, rr;
    int e_we, e_wa, e_wd, e_fv, e_fa, e_fd, e_st, e_occ, e_rdy;
  } vec_t;

  ent_t mq[$];
  vec_t tbl[$];
  int   errors = 0;
  int   checks = 0;

  logic             m_ready, m_we, m_fv, m_st;
  logic [ASIZE-1:0] m_wa, m_fa;
  logic [DSIZE-1:0] m_wd, m_fd;
  int               m_occ;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic add_row(input int rst_i, vld, wen, rd, res, gnt, rl, rr,
                         input int we, wa, wd, fv, fa, fd, st, occ, rdy);
    vec_t v;
    v = '{rst_i, vld, wen, rd, res, gnt, rl, rr, we, wa, wd, fv, fa, fd, st, occ, rdy};
    tbl.push_back(v);
  endtask

  // Expected outputs from the current queue contents and inputs.
  task automatic model_eval();
    m_ready = !rst && (mq.size() < DEPTH);
    m_we    = !rst && (mq.size() > 0) && mq[0].wen;
    m_wa    = m_we ? mq[0].addr : '0;
    m_wd    = m_we ? mq[0].data : '0;
    m_fv    = 1'b0;
    m_fa    = '0;
    m_fd    = '0;
    foreach (mq[i]) begin
      if (mq[i].wen) begin
        m_fv = 1'b1;
        m_fa = mq[i].addr;
        m_fd = mq[i].data;
      end
    end
    m_st = 1'b0;
    foreach (mq[i]) begin
      if (mq[i].wen && ((mq[i].addr == RLAddr && RLAddr != m_fa) ||
                        (mq[i].addr == RRAddr && RRAddr != m_fa)))
        m_st = 1'b1;
    end
    m_occ = mq.size();
  endtask

  // Clock-edge effect on the model queue; call after model_eval for this cycle.
  task automatic model_step();
    ent_t e;
    if (rst) begin
      mq.delete();
    end else begin
      if (mq.size() > 0 && (!mq[0].wen || rf_grant)) void'(mq.pop_front());
      if (ex_valid && m_ready) begin
        e.wen = ex_wen; e.addr = ex_rd_addr; e.data = ex_result;
        mq.push_back(e);
      end
    end
  endtask

  task automatic cmp_model();
    chk("ex_ready", 32'(ex_ready), 32'(m_ready));
    chk("rf_we", 32'(rf_we), 32'(m_we));
    if (m_we) begin
      chk("rf_waddr", 32'(rf_waddr), 32'(m_wa));
      chk("rf_wdata", rf_wdata, m_wd);
    end
    chk("fwd_valid", 32'(fwd_valid), 32'(m_fv));
    chk("EX_WB_RDAddr", 32'(EX_WB_RDAddr), 32'(m_fa));
    chk("FromEX", FromEX, m_fd);
    chk("hazard_stall", 32'(hazard_stall), 32'(m_st));
    chk("occupancy", 32'(occupancy), 32'(m_occ));
  endtask

  task automatic finish_cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; ex_valid = 1'b0; ex_wen = 1'b0; ex_rd_addr = '0; ex_result = '0;
    rf_grant = 1'b0; RLAddr = '0; RRAddr = '0;

    //      rst vld wen rd  res gnt rl rr | we wa wd fv fa fd st occ rdy
    add_row(1, 0, 0, 0,  0,  0, 0,  0,    0, 0, 0, 0, 0, 0, 0, 0, 0);
    add_row(0, 1, 1, 10, 31, 1, 0,  0,    0, 0, 0, 0, 0, 0, 0, 0, 1);
    add_row(0, 0, 0, 0,  0,  1, 10, 0,    1, 10, 31, 1, 10, 31, 0, 1, 1);
    add_row(0, 1, 1, 10, 31, 0, 0,  0,    0, 0, 0, 0, 0, 0, 0, 0, 1);
    add_row(0, 1, 1, 2,  16, 0, 0,  0,    1, 10, 31, 1, 10, 31, 0, 1, 1);
    add_row(0, 0, 0, 0,  0,  0, 10, 0,    1, 10, 31, 1, 2, 16, 1, 2, 0);
    add_row(0, 0, 0, 0,  0,  0, 2,  0,    1, 10, 31, 1, 2, 16, 0, 2, 0);
    add_row(0, 0, 0, 0,  0,  0, 0,  10,   1, 10, 31, 1, 2, 16, 1, 2, 0);
    add_row(0, 1, 1, 9,  9,  1, 0,  0,    1, 10, 31, 1, 2, 16, 0, 2, 0);
    add_row(0, 0, 0, 0,  0,  1, 0,  0,    1, 2, 16, 1, 2, 16, 0, 1, 1);
    add_row(0, 1, 1, 10, 31, 0, 0,  0,    0, 0, 0, 0, 0, 0, 0, 0, 1);
    add_row(0, 1, 1, 10, 45, 0, 0,  0,    1, 10, 31, 1, 10, 31, 0, 1, 1);
    add_row(0, 0, 0, 0,  0,  0, 10, 0,    1, 10, 31, 1, 10, 45, 0, 2, 0);
    add_row(0, 0, 0, 0,  0,  1, 10, 0,    1, 10, 31, 1, 10, 45, 0, 2, 0);
    add_row(0, 0, 0, 0,  0,  1, 0,  0,    1, 10, 45, 1, 10, 45, 0, 1, 1);
    add_row(0, 1, 0, 7,  99, 0, 0,  0,    0, 0, 0, 0, 0, 0, 0, 0, 1);
    add_row(0, 0, 0, 0,  0,  0, 7,  0,    0, 0, 0, 0, 0, 0, 0, 1, 1);
    add_row(0, 0, 0, 0,  0,  0, 7,  0,    0, 0, 0, 0, 0, 0, 0, 0, 1);
    add_row(0, 1, 1, 3,  77, 0, 0,  0,    0, 0, 0, 0, 0, 0, 0, 0, 1);
    add_row(0, 1, 1, 4,  88, 0, 0,  0,    1, 3, 77, 1, 3, 77, 0, 1, 1);
    add_row(1, 0, 0, 0,  0,  1, 0,  0,    0, 0, 0, 1, 4, 88, 0, 2, 0);
    add_row(0, 0, 0, 0,  0,  1, 0,  0,    0, 0, 0, 0, 0, 0, 0, 0, 1);
    add_row(0, 0, 0, 0,  0,  1, 3,  4,    0, 0, 0, 0, 0, 0, 0, 0, 1);

    @(negedge clk);
    foreach (tbl[k]) begin
      rst = tbl[k].rst[0]; ex_valid = tbl[k].vld[0]; ex_wen = tbl[k].wen[0];
      ex_rd_addr = tbl[k].rd[ASIZE-1:0]; ex_result = tbl[k].res;
      rf_grant = tbl[k].gnt[0]; RLAddr = tbl[k].rl[ASIZE-1:0]; RRAddr = tbl[k].rr[ASIZE-1:0];
      #1;
      model_eval();
      chk("t_ex_ready", 32'(ex_ready), tbl[k].e_rdy);
      chk("t_rf_we", 32'(rf_we), tbl[k].e_we);
      if (tbl[k].e_we != 0) begin
        chk("t_rf_waddr", 32'(rf_waddr), tbl[k].e_wa);
        chk("t_rf_wdata", rf_wdata, tbl[k].e_wd);
      end
      chk("t_fwd_valid", 32'(fwd_valid), tbl[k].e_fv);
      chk("t_EX_WB_RDAddr", 32'(EX_WB_RDAddr), tbl[k].e_fa);
      chk("t_FromEX", FromEX, tbl[k].e_fd);
      chk("t_hazard_stall", 32'(hazard_stall), tbl[k].e_st);
      chk("t_occupancy", 32'(occupancy), tbl[k].e_occ);
      finish_cycle();
    end

    // Random traffic with narrow address range to provoke matches and shadowing.
    for (int n = 0; n < 800; n++) begin
      rst        = ($urandom_range(0, 63) == 0);
      ex_valid   = ($urandom_range(0, 3) != 0);
      ex_wen     = ($urandom_range(0, 3) != 0);
      ex_rd_addr = ASIZE'($urandom_range(0, 3));
      ex_result  = $urandom;
      rf_grant   = ($urandom_range(0, 2) != 0);
      RLAddr     = ASIZE'($urandom_range(0, 4));
      RRAddr     = ASIZE'($urandom_range(0, 4));
      #1;
      model_eval();
      cmp_model();
      finish_cycle();
    end

    // Saturated push with grant held across several pointer wraps.
    for (int n = 0; n < 16; n++) begin
      rst = 1'b0; ex_valid = 1'b1; ex_wen = 1'b1;
      ex_rd_addr = ASIZE'(n % 4); ex_result = 32'(1000 + n);
      rf_grant = 1'b1; RLAddr = ASIZE'(n % 3); RRAddr = ASIZE'(n % 5);
      #1;
      model_eval();
      cmp_model();
      finish_cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
